// File: rtl/sram_arbiter_if.sv
// Requester, controller and status signals of the two-port SRAM arbiter.
// slave = arbiter side; master = requesters plus SRAM controller.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_w_en;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant_id;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_done, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_done, p1_rdata,
    output mem_w_en, mem_r_en, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output busy, grant_id
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_done, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_done, p1_rdata,
    input  mem_w_en, mem_r_en, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a single ready-based SRAM controller:
// grant, latch request, hold enables until mem_ready, then a one-cycle done.
module sram_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic              any_req;
  logic              win;
  logic              last_grant;
  logic              grant;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign any_req = bus.p0_req | bus.p1_req;

  // With both requesting, round-robin favours the port that did not win last.
  always_comb begin
    if (bus.p0_req && bus.p1_req)
      win = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
    else
      win = bus.p1_req;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  if (bus.mem_ready) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_we     <= win ? bus.p1_we    : bus.p0_we;
        lat_addr   <= win ? bus.p1_addr  : bus.p0_addr;
        lat_wdata  <= win ? bus.p1_wdata : bus.p0_wdata;
        grant      <= win;
        last_grant <= win;
      end
      if (state == ACCESS && bus.mem_ready && !lat_we) begin
        if (grant) rdata1 <= bus.mem_rdata;
        else       rdata0 <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_w_en  = 1'b0;
    bus.mem_r_en  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.p0_done   = 1'b0;
    bus.p1_done   = 1'b0;
    case (state)
      ACCESS: begin
        bus.mem_w_en  = lat_we;
        bus.mem_r_en  = ~lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
      end
      RESP: begin
        bus.p0_done = ~grant;
        bus.p1_done = grant;
      end
      default: ;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant;
  assign bus.p0_rdata = rdata0;
  assign bus.p1_rdata = rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each behind a
// 6-cycle SRAM controller model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  sram_arbiter #(.PRIO_MODE(0), .ADDR_W(32), .DATA_W(32)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  sram_arbiter #(.PRIO_MODE(1), .ADDR_W(32), .DATA_W(32)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Controller model: ready in the 6th consecutive enabled cycle, word-indexed store.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  int          cnt_a;
  int          cnt_b;

  always @(posedge clk) begin
    if (rst) begin
      cnt_a <= 0;
      mem_a[16] <= 32'hDEADBEEF;
    end else if (bus_a.mem_w_en || bus_a.mem_r_en) begin
      if (cnt_a == 5) begin
        cnt_a <= 0;
        if (bus_a.mem_w_en) mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wdata;
      end else cnt_a <= cnt_a + 1;
    end else cnt_a <= 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt_b <= 0;
      mem_b[16] <= 32'hDEADBEEF;
    end else if (bus_b.mem_w_en || bus_b.mem_r_en) begin
      if (cnt_b == 5) begin
        cnt_b <= 0;
        if (bus_b.mem_w_en) mem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_wdata;
      end else cnt_b <= cnt_b + 1;
    end else cnt_b <= 0;
  end

  assign bus_a.mem_ready = (bus_a.mem_w_en || bus_a.mem_r_en) && (cnt_a == 5);
  assign bus_b.mem_ready = (bus_b.mem_w_en || bus_b.mem_r_en) && (cnt_b == 5);
  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[7:2]];
  assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One uncontended access on bus_a over a fixed 12-cycle window; cycle 0 is the request cycle.
  task automatic run_a(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int done_cyc, output int ndone,
                       output int ren, output int wen, output int other_done);
    done_cyc = -1; ndone = 0; ren = 0; wen = 0; other_done = 0;
    if (port) begin
      bus_a.p1_we = we; bus_a.p1_addr = addr; bus_a.p1_wdata = wdata; bus_a.p1_req = 1'b1;
    end else begin
      bus_a.p0_we = we; bus_a.p0_addr = addr; bus_a.p0_wdata = wdata; bus_a.p0_req = 1'b1;
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus_a.mem_r_en) ren++;
      if (bus_a.mem_w_en) wen++;
      if ((port ? bus_a.p0_done : bus_a.p1_done) === 1'b1) other_done++;
      if ((port ? bus_a.p1_done : bus_a.p0_done) === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        bus_a.p0_req = 1'b0;
        bus_a.p1_req = 1'b0;
      end
    end
    bus_a.p0_req = 1'b0;
    bus_a.p1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if ({bus_a.busy, bus_a.grant_id, bus_a.mem_w_en, bus_a.mem_r_en, bus_a.p0_done, bus_a.p1_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b expected 000000",
               {bus_a.busy, bus_a.grant_id, bus_a.mem_w_en, bus_a.mem_r_en, bus_a.p0_done, bus_a.p1_done});
    end
    checks++;
    if ({bus_a.mem_addr, bus_a.mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: got %h expected 0", {bus_a.mem_addr, bus_a.mem_wdata});
    end
    checks++;
    if ({bus_a.p0_rdata, bus_a.p1_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", {bus_a.p0_rdata, bus_a.p1_rdata});
    end
    checks++;
    if ({bus_b.busy, bus_b.grant_id, bus_b.mem_w_en, bus_b.mem_r_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b expected 0000",
               {bus_b.busy, bus_b.grant_id, bus_b.mem_w_en, bus_b.mem_r_en});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    int dc, nd, ren, wen, od;
    run_a(1'b0, 1'b0, 32'h40, 32'h0, dc, nd, ren, wen, od);
    checks++;
    if (dc != 7 || nd != 1) begin
      errors++;
      $display("FAIL read_p0_done: got cycle %0d count %0d expected cycle 7 count 1", dc, nd);
    end
    checks++;
    if (ren != 6 || wen != 0) begin
      errors++;
      $display("FAIL read_p0_enables: got r_en %0d w_en %0d expected 6 and 0", ren, wen);
    end
    checks++;
    if (bus_a.p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_p0_rdata: got %h expected deadbeef", bus_a.p0_rdata);
    end
    checks++;
    if (bus_a.p1_rdata !== 32'h0 || od != 0) begin
      errors++;
      $display("FAIL read_p0_other: got p1_rdata %h p1_done %0d expected 0 and 0", bus_a.p1_rdata, od);
    end
  endtask

  task automatic test_write_read_p1();
    int dc, nd, ren, wen, od, total;
    run_a(1'b1, 1'b1, 32'h80, 32'h12345678, dc, nd, ren, wen, od);
    total = nd;
    checks++;
    if (dc != 7 || wen != 6 || ren != 0) begin
      errors++;
      $display("FAIL write_p1: got done %0d w_en %0d r_en %0d expected 7 6 0", dc, wen, ren);
    end
    checks++;
    if (bus_a.p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_p1_rdata: got %h expected 0", bus_a.p1_rdata);
    end
    run_a(1'b1, 1'b0, 32'h80, 32'h0, dc, nd, ren, wen, od);
    total += nd;
    checks++;
    if (dc != 7 || wen != 0 || ren != 6) begin
      errors++;
      $display("FAIL read_p1: got done %0d w_en %0d r_en %0d expected 7 0 6", dc, wen, ren);
    end
    checks++;
    if (bus_a.p1_rdata !== 32'h12345678 || bus_a.p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_p1_rdata: got p1 %h p0 %h expected 12345678 deadbeef",
               bus_a.p1_rdata, bus_a.p0_rdata);
    end
    checks++;
    if (total != 2) begin
      errors++;
      $display("FAIL p1_done_total: got %0d expected 2", total);
    end
  endtask

  task automatic test_rr_contention();
    int n = 0, d0 = 0, d1 = 0, both = 0, last_c = -1;
    logic [3:0] gseq = '0;
    logic [3:0] dseq = '0;
    bus_a.p0_we = 1'b0; bus_a.p0_addr = 32'h40;
    bus_a.p1_we = 1'b0; bus_a.p1_addr = 32'h80;
    bus_a.p0_req = 1'b1; bus_a.p1_req = 1'b1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      step();
      if (bus_a.mem_w_en && bus_a.mem_r_en) both++;
      if (bus_a.p0_done || bus_a.p1_done) begin
        gseq = {gseq[2:0], bus_a.grant_id};
        dseq = {dseq[2:0], bus_a.p1_done};
        if (bus_a.p0_done) d0++;
        if (bus_a.p1_done) d1++;
        n++;
        last_c = c;
        if (n == 4) begin bus_a.p0_req = 1'b0; bus_a.p1_req = 1'b0; end
      end
    end
    bus_a.p0_req = 1'b0; bus_a.p1_req = 1'b0;
    step();
    checks++;
    if (gseq !== 4'b0101) begin
      errors++;
      $display("FAIL rr_grant_seq: got %b expected 0101", gseq);
    end
    checks++;
    if (dseq !== 4'b0101 || d0 != 2 || d1 != 2) begin
      errors++;
      $display("FAIL rr_done_seq: got %b (p0 %0d p1 %0d) expected 0101 (2 2)", dseq, d0, d1);
    end
    checks++;
    if (last_c != 31 || both != 0) begin
      errors++;
      $display("FAIL rr_timing: got 4th done cycle %0d dual-enable %0d expected 31 and 0", last_c, both);
    end
    checks++;
    if (bus_a.p0_rdata !== 32'hDEADBEEF || bus_a.p1_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rr_rdata: got p0 %h p1 %h expected deadbeef 12345678",
               bus_a.p0_rdata, bus_a.p1_rdata);
    end
  endtask

  task automatic test_fixed_prio();
    int n0 = 0, gbad = 0, p1c = -1;
    logic p1g = 1'b0;
    bus_b.p0_we = 1'b0; bus_b.p0_addr = 32'h40; bus_b.p0_wdata = '0;
    bus_b.p1_we = 1'b0; bus_b.p1_addr = 32'h40; bus_b.p1_wdata = '0;
    bus_b.p0_req = 1'b1; bus_b.p1_req = 1'b1;
    for (int c = 1; c <= 60 && p1c < 0; c++) begin
      step();
      if (bus_b.p0_done) begin
        n0++;
        if (bus_b.grant_id !== 1'b0) gbad++;
        if (n0 == 3) bus_b.p0_req = 1'b0;
      end
      if (bus_b.p1_done) begin
        p1c = c;
        p1g = bus_b.grant_id;
        bus_b.p1_req = 1'b0;
      end
    end
    bus_b.p0_req = 1'b0; bus_b.p1_req = 1'b0;
    step();
    checks++;
    if (n0 != 3 || gbad != 0) begin
      errors++;
      $display("FAIL prio_p0_wins: got %0d p0 grants (%0d bad) expected 3 (0)", n0, gbad);
    end
    checks++;
    if (p1c != 31 || p1g !== 1'b1) begin
      errors++;
      $display("FAIL prio_p1_after: got done cycle %0d grant %b expected 31 and 1", p1c, p1g);
    end
    checks++;
    if (bus_b.p1_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_p1_rdata: got %h expected deadbeef", bus_b.p1_rdata);
    end
  endtask

  task automatic test_input_change();
    int bad = 0, gbad = 0, p1d = 0, dc = -1;
    bus_a.p0_we = 1'b0; bus_a.p0_addr = 32'h40; bus_a.p0_req = 1'b1;
    bus_a.p1_we = 1'b1; bus_a.p1_addr = 32'h80; bus_a.p1_wdata = 32'hFFFF0000;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 2) bus_a.p0_addr = 32'h44;
      if (c == 3) bus_a.p1_req = 1'b1;
      if (c == 4) bus_a.p1_req = 1'b0;
      if (bus_a.mem_r_en && bus_a.mem_addr !== 32'h40) bad++;
      if (bus_a.busy && bus_a.grant_id !== 1'b0) gbad++;
      if (bus_a.p1_done || bus_a.mem_w_en) p1d++;
      if (bus_a.p0_done && dc < 0) begin dc = c; bus_a.p0_req = 1'b0; end
    end
    bus_a.p0_req = 1'b0;
    checks++;
    if (bad != 0 || dc != 7) begin
      errors++;
      $display("FAIL addr_hold: got %0d wrong-addr cycles, done cycle %0d expected 0 and 7", bad, dc);
    end
    checks++;
    if (gbad != 0 || p1d != 0) begin
      errors++;
      $display("FAIL port_indep: got %0d grant errs %0d p1 activity expected 0 and 0", gbad, p1d);
    end
    checks++;
    if (bus_a.p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL addr_hold_rdata: got %h expected deadbeef", bus_a.p0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0, dc = -1;
    logic g = 1'b1;
    bus_a.p0_we = 1'b0; bus_a.p0_addr = 32'h40; bus_a.p0_req = 1'b1;
    repeat (3) step();
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.mem_r_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got busy %b r_en %b expected 1 1", bus_a.busy, bus_a.mem_r_en);
    end
    rst = 1'b1;
    bus_a.p0_req = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if ({bus_a.busy, bus_a.mem_w_en, bus_a.mem_r_en, bus_a.p0_done, bus_a.grant_id} !== 5'b0
        || bus_a.p0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got ctrl %b p0_rdata %h expected 00000 and 0",
               {bus_a.busy, bus_a.mem_w_en, bus_a.mem_r_en, bus_a.p0_done, bus_a.grant_id},
               bus_a.p0_rdata);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus_a.p0_done || bus_a.p1_done || bus_a.busy) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL mid_no_done: got %0d active cycles expected 0", dn);
    end
    bus_a.p1_we = 1'b0; bus_a.p1_addr = 32'h80;
    bus_a.p0_req = 1'b1; bus_a.p1_req = 1'b1;
    for (int c = 1; c <= 12 && dc < 0; c++) begin
      step();
      if (bus_a.p0_done || bus_a.p1_done) begin
        dc = c;
        g = bus_a.p1_done;
        bus_a.p0_req = 1'b0; bus_a.p1_req = 1'b0;
      end
    end
    bus_a.p0_req = 1'b0; bus_a.p1_req = 1'b0;
    step();
    checks++;
    if (dc != 7 || g !== 1'b0 || bus_a.p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_reset_access: got done %0d port %b rdata %h expected 7 0 deadbeef",
               dc, g, bus_a.p0_rdata);
    end
  endtask

  initial begin
    bus_a.p0_req = 1'b0; bus_a.p0_we = 1'b0; bus_a.p0_addr = '0; bus_a.p0_wdata = '0;
    bus_a.p1_req = 1'b0; bus_a.p1_we = 1'b0; bus_a.p1_addr = '0; bus_a.p1_wdata = '0;
    bus_b.p0_req = 1'b0; bus_b.p0_we = 1'b0; bus_b.p0_addr = '0; bus_b.p0_wdata = '0;
    bus_b.p1_req = 1'b0; bus_b.p1_we = 1'b0; bus_b.p1_addr = '0; bus_b.p1_wdata = '0;
    test_reset();
    test_single_read();
    test_write_read_p1();
    test_rr_contention();
    test_fixed_prio();
    test_input_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single SRAM controller (32-bit word interface, multi-cycle, ready-based).
- Port 0 is the memory-stage data path; port 1 is the secondary master (instruction fetch or DMA).
- Picks one request, latches it, holds the controller enables until the access completes, returns read data plus a one-cycle done pulse, then releases the controller.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- ADDR_W, 32, address width, all ports.
- DATA_W, 32, data width, all ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- p0_req  input  1  port 0 request; level; held high until p0_done is seen.
- p0_we  input  1  port 0 direction; 1 = write, 0 = read.
- p0_addr  input  ADDR_W  port 0 byte address.
- p0_wdata  input  DATA_W  port 0 write data.
- p0_done  output  1  one-cycle completion pulse to port 0.
- p0_rdata  output  DATA_W  last read data returned to port 0.
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata  same as port 0, for port 1.
- mem_w_en  output  1  write enable to the SRAM controller.
- mem_r_en  output  1  read enable to the SRAM controller.
- mem_addr  output  ADDR_W  address to the SRAM controller.
- mem_wdata  output  DATA_W  write data to the SRAM controller.
- mem_ready  input  1  controller ready; goes high in the final cycle of a pending access.
- mem_rdata  input  DATA_W  controller read data; valid on the edge where mem_ready=1 with mem_r_en=1.
- busy  output  1  high whenever the state is not IDLE.
- grant_id  output  1  port currently owning the controller; holds its last value in IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - mem_w_en=0, mem_r_en=0, mem_addr=0, mem_wdata=0.
  - p0_done=p1_done=0, p0_rdata=p1_rdata=0.
  - busy=0, grant_id=0.
  - last_grant=1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select a winner, and on the edge:
    - latch the winner's we, addr and wdata into internal registers;
    - set grant_id and last_grant to the winner;
    - go to ACCESS.
- Winner selection:
  - Only one req high: that port wins.
  - Both high, PRIO_MODE=0: the port not equal to last_grant wins.
  - Both high, PRIO_MODE=1: port 0 wins.
- ACCESS:
  - Drive mem_w_en = latched we and mem_r_en = ~latched we; exactly one is high every ACCESS cycle.
  - Drive mem_addr and mem_wdata from the latched registers. Requester input changes after the grant are ignored.
  - On the edge where mem_ready=1, go to RESP.
  - On that edge, if the access is a read, capture mem_rdata into the granted port's rdata register.
  - The other port's rdata is never modified. Writes leave both rdata registers unchanged.
- RESP:
  - Enables are low, mem_addr=0, mem_wdata=0. This lets the controller counter return to idle.
  - The granted port's done=1 for exactly this cycle.
  - Unconditionally go to IDLE.
- Latency (controller MEMORY_LATENCY=6, uncontended):
  - req seen in IDLE at cycle 0.
  - ACCESS in cycles 1–6.
  - done high in cycle 7.
- Throughput: back-to-back accesses are separated by one IDLE cycle, i.e. 8 cycles per access.
- Requester protocol:
  - req must stay high until done is seen.
  - req must be low by the cycle after done; otherwise it is treated as a new request.
- Arbitration timing:
  - A request arriving while the state is not IDLE waits; it is evaluated in the next IDLE cycle.
  - Round-robin guarantees that, with both ports requesting continuously, grants alternate 0,1,0,1.
- Port independence: a req toggling on the non-granted port during ACCESS has no effect on the current transfer.
- Reset mid-operation:
  - Synchronous reset in any state forces all reset values on the next edge.
  - Any in-flight access is dropped and no done is issued.
  - The controller shares rst, so the two stay consistent.
- Protected outputs: mem_w_en and mem_r_en are never both high.
- Enable timing: no enable is asserted in IDLE or RESP.

Test Plan:
- Single read, port 0: preload 0xDEADBEEF at addr 0x40; pulse-hold p0_req, p0_we=0 -> mem_r_en high for 6 cycles, p0_done exactly 1 cycle at cycle 7, p0_rdata=0xDEADBEEF, p1_rdata stays 0.
- Write then read, port 1: write 0x12345678 to 0x80, then read 0x80 -> mem_w_en only during the write ACCESS, p1_rdata=0x12345678, p1_done pulses twice total.
- Contention, PRIO_MODE=0: both req high continuously for 4 accesses -> grant_id sequence 0,1,0,1; each port gets 2 done pulses.
- Contention, PRIO_MODE=1: both req high, port 0 re-requests after every done -> port 0 granted every time, port 1 never granted while port 0 requests.
- Input change during access: change p0_addr from 0x40 to 0x44 in ACCESS cycle 2 -> mem_addr stays 0x40 for the whole access.
- Reset mid-operation: assert rst in ACCESS cycle 3 -> next cycle state IDLE, all enables 0, no done, busy=0; a subsequent request completes normally.
